// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: request sizes, FSM states and the
// store lane-steering helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_W  = 3'd0,
    OP_H  = 3'd1,
    OP_HU = 3'd2,
    OP_B  = 3'd3,
    OP_BU = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_W:          op_legal = (off == 2'b00);
      OP_H, OP_HU:   op_legal = (off[0] == 1'b0);
      OP_B, OP_BU:   op_legal = 1'b1;
      default:       op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_H, OP_HU:   store_be = off[1] ? 4'b1100 : 4'b0011;
      OP_B, OP_BU:   store_be = 4'b0001 << off;
      default:       store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the narrow source across all lanes so the memory picks by byte-enable.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] src);
    case (op)
      OP_H, OP_HU:   store_data = {2{src[15:0]}};
      OP_B, OP_BU:   store_data = {4{src[7:0]}};
      default:       store_data = src;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Little-endian load lane selection with sign or zero extension.
module load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[8*offset +: 8];
    half_sel = offset[1] ? data[31:16] : data[15:0];
    case (op)
      OP_H:    result = {{16{half_sel[15]}}, half_sel};
      OP_HU:   result = {16'h0000, half_sel};
      OP_B:    result = {{24{byte_sel[7]}}, byte_sel};
      OP_BU:   result = {24'h000000, byte_sel};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues one data-memory access per instruction over a
// req/gnt/rvalid handshake and stalls the pipeline until it completes.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              exc,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata
);

  state_e      state;
  logic        we_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic        legal;
  logic [31:0] ext_data;

  assign legal = op_legal(req_op, req_addr[1:0]);

  // The DONE cycle is when the pipeline advances, so a new request is only
  // considered in IDLE.
  assign stall = !reset && ((state == ST_REQ) || (state == ST_WAIT) ||
                            ((state == ST_IDLE) && req_valid && legal));
  assign exc   = !reset && (state == ST_IDLE) && req_valid && !legal;

  load_ext u_load_ext (
    .data   (dm_rdata),
    .offset (off_q),
    .op     (op_q),
    .result (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      op_q        <= '0;
      off_q       <= '0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_be       <= '0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && legal) begin
            we_q     <= req_we;
            op_q     <= req_op;
            off_q    <= req_addr[1:0];
            dm_req   <= 1'b1;
            dm_we    <= req_we;
            dm_be    <= store_be(req_op, req_addr[1:0]);
            dm_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            dm_wdata <= req_we ? store_data(req_op, req_wdata) : '0;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dm_gnt) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_be    <= '0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            if (we_q) begin
              state <= ST_DONE;
            end else if (dm_rvalid) begin
              rdata       <= ext_data;
              rdata_valid <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dm_rvalid) begin
            rdata       <= ext_data;
            rdata_valid <= 1'b1;
            state       <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads of every size/offset, illegal
// accesses, grant back-pressure and reset during an outstanding load.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        stall, exc, rdata_valid;
  logic [31:0] rdata;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .exc(exc), .rdata(rdata), .rdata_valid(rdata_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata)
  );

  // Drives one legal access to completion. gnt_wait = REQ cycles without grant,
  // rv_wait = cycles after grant until rvalid (0 = same cycle as grant).
  task automatic run_access(
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  int          gnt_wait,
    input  int          rv_wait,
    input  logic [31:0] mem_word,
    output int          stall_cnt,
    output int          rv_cnt,
    output logic [31:0] got_rdata,
    output logic [3:0]  got_be,
    output logic [31:0] got_addr,
    output logic [31:0] got_wdata,
    output logic        got_we,
    output bit          stable,
    output bit          timed_out
  );
    int  reqc = 0;
    int  wc = 0;
    bit  granted = 0;
    bit  first = 1;
    stall_cnt = 0; rv_cnt = 0; got_rdata = '0; stable = 1; timed_out = 1;
    got_be = '0; got_addr = '0; got_wdata = '0; got_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) begin
        @(negedge clk);
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
      end
      #1;
      if (stall) stall_cnt++;
      if (rdata_valid) begin
        rv_cnt++;
        got_rdata = rdata;
      end
      if (c > 0 && !stall) begin
        timed_out = 0;
        break;
      end
      if (dm_req) begin
        if (!stall) stable = 0;
        if (first) begin
          first = 0;
          got_be = dm_be; got_addr = dm_addr; got_wdata = dm_wdata; got_we = dm_we;
        end else if (dm_be !== got_be || dm_addr !== got_addr ||
                     dm_wdata !== got_wdata || dm_we !== got_we) begin
          stable = 0;
        end
        if (reqc == gnt_wait) begin
          dm_gnt = 1'b1;
          granted = 1;
          if (!we && rv_wait == 0) begin
            dm_rvalid = 1'b1; dm_rdata = mem_word;
          end
        end else begin
          reqc++;
        end
      end else if (granted && !we) begin
        wc++;
        if (wc == rv_wait) begin
          dm_rvalid = 1'b1; dm_rdata = mem_word;
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = '0;
    @(negedge clk); #1;
    checks++;
    if ({stall, exc, rdata_valid, dm_req, dm_we} !== 5'b0 || dm_be !== 4'h0 ||
        dm_addr !== 32'h0 || dm_wdata !== 32'h0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: stall=%b exc=%b rv=%b req=%b we=%b be=%h addr=%h wd=%h rdata=%h, want all zero",
               stall, exc, rdata_valid, dm_req, dm_we, dm_be, dm_addr, dm_wdata, rdata);
    end
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_store_byte;
    int sc, rc; logic [31:0] rd, ad, wd; logic [3:0] be; logic we; bit st, to;
    run_access(1'b1, 3'd3, 32'h0000_1003, 32'h1234_56AB, 0, 0, '0,
               sc, rc, rd, be, ad, wd, we, st, to);
    checks++;
    if (to || be !== 4'b1000 || wd !== 32'hABAB_ABAB || ad !== 32'h0000_1000 || we !== 1'b1) begin
      failures++;
      $display("FAIL sb_port: to=%0d be=%b wd=%h addr=%h we=%b, want be=1000 wd=abababab addr=00001000 we=1",
               to, be, wd, ad, we);
    end
    checks++;
    if (sc != 2 || rc != 0) begin
      failures++;
      $display("FAIL sb_timing: stalls=%0d rdata_valid=%0d, want 2 and 0", sc, rc);
    end
  endtask

  task automatic test_load_half;
    int sc, rc; logic [31:0] rd, ad, wd; logic [3:0] be; logic we; bit st, to;
    run_access(1'b0, 3'd1, 32'h0000_2002, '0, 0, 1, 32'h8001_7FFF,
               sc, rc, rd, be, ad, wd, we, st, to);
    checks++;
    if (to || rd !== 32'hFFFF_8001 || sc != 3 || rc != 1 || be !== 4'b1100 || ad !== 32'h0000_2000) begin
      failures++;
      $display("FAIL lh: to=%0d rdata=%h stalls=%0d rv=%0d be=%b addr=%h, want ffff8001 3 1 1100 00002000",
               to, rd, sc, rc, be, ad);
    end
    run_access(1'b0, 3'd2, 32'h0000_2002, '0, 0, 1, 32'h8001_7FFF,
               sc, rc, rd, be, ad, wd, we, st, to);
    checks++;
    if (to || rd !== 32'h0000_8001 || sc != 3 || rc != 1) begin
      failures++;
      $display("FAIL lhu: to=%0d rdata=%h stalls=%0d rv=%0d, want 00008001 3 1", to, rd, sc, rc);
    end
    @(negedge clk); #1;
    checks++;
    if (rdata !== 32'h0000_8001 || rdata_valid !== 1'b0) begin
      failures++;
      $display("FAIL rdata_hold: rdata=%h rv=%b, want 00008001 0", rdata, rdata_valid);
    end
  endtask

  task automatic test_load_bytes;
    logic [31:0] lb_exp [4] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
    logic [31:0] lbu_exp[4] = '{32'h0000_0001, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0080};
    int sc, rc; logic [31:0] rd, ad, wd; logic [3:0] be; logic we; bit st, to;
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, 3'd3, 32'h0000_4000 + i, '0, 0, 0, 32'h80FF_7F01,
                 sc, rc, rd, be, ad, wd, we, st, to);
      checks++;
      if (to || rd !== lb_exp[i] || sc != 2 || rc != 1 || be !== (4'b0001 << i)) begin
        failures++;
        $display("FAIL lb_off%0d: to=%0d rdata=%h stalls=%0d rv=%0d be=%b, want %h 2 1 %b",
                 i, to, rd, sc, rc, be, lb_exp[i], 4'b0001 << i);
      end
      run_access(1'b0, 3'd4, 32'h0000_4000 + i, '0, 0, 0, 32'h80FF_7F01,
                 sc, rc, rd, be, ad, wd, we, st, to);
      checks++;
      if (to || rd !== lbu_exp[i] || rc != 1) begin
        failures++;
        $display("FAIL lbu_off%0d: to=%0d rdata=%h rv=%0d, want %h 1", i, to, rd, rc, lbu_exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int sc, rc; logic [31:0] rd, ad, wd; logic [3:0] be; logic we; bit st, to;
    run_access(1'b1, 3'd0, 32'h0000_5000, 32'hCAFE_F00D, 0, 0, '0,
               sc, rc, rd, be, ad, wd, we, st, to);
    checks++;
    if (to || be !== 4'b1111 || wd !== 32'hCAFE_F00D || sc != 2 || rc != 0) begin
      failures++;
      $display("FAIL sw: to=%0d be=%b wd=%h stalls=%0d rv=%0d, want 1111 cafef00d 2 0", to, be, wd, sc, rc);
    end
    run_access(1'b0, 3'd0, 32'h0000_5000, '0, 0, 2, 32'hCAFE_F00D,
               sc, rc, rd, be, ad, wd, we, st, to);
    checks++;
    if (to || rd !== 32'hCAFE_F00D || sc != 4 || rc != 1 || we !== 1'b0) begin
      failures++;
      $display("FAIL lw: to=%0d rdata=%h stalls=%0d rv=%0d we=%b, want cafef00d 4 1 0", to, rd, sc, rc, we);
    end
  endtask

  task automatic test_illegal;
    logic        we_v[3]   = '{1'b1, 1'b0, 1'b0};
    logic [2:0]  op_v[3]   = '{3'd0, 3'd1, 3'd6};
    logic [31:0] addr_v[3] = '{32'h0000_6002, 32'h0000_6001, 32'h0000_6000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = we_v[i]; req_op = op_v[i]; req_addr = addr_v[i]; req_wdata = 32'h1;
      #1;
      checks++;
      if (exc !== 1'b1 || stall !== 1'b0 || dm_req !== 1'b0) begin
        failures++;
        $display("FAIL illegal%0d_same_cycle: exc=%b stall=%b dm_req=%b, want 1 0 0", i, exc, stall, dm_req);
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++;
      if (dm_req !== 1'b0 || exc !== 1'b0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL illegal%0d_no_issue: dm_req=%b exc=%b stall=%b, want 0 0 0", i, dm_req, exc, stall);
      end
    end
  endtask

  task automatic test_gnt_backpressure;
    int sc, rc; logic [31:0] rd, ad, wd; logic [3:0] be; logic we; bit st, to;
    run_access(1'b1, 3'd1, 32'h0000_7002, 32'h0000_BEEF, 5, 0, '0,
               sc, rc, rd, be, ad, wd, we, st, to);
    checks++;
    if (to || !st || sc != 7 || be !== 4'b1100 || wd !== 32'hBEEF_BEEF || ad !== 32'h0000_7000) begin
      failures++;
      $display("FAIL gnt_wait: to=%0d stable=%0d stalls=%0d be=%b wd=%h addr=%h, want 0 1 7 1100 beefbeef 00007000",
               to, st, sc, be, wd, ad);
    end
    #1;
    checks++;
    if (dm_req !== 1'b0) begin
      failures++;
      $display("FAIL gnt_wait_req_drop: dm_req=%b in done, want 0", dm_req);
    end
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0000_3000;
    @(negedge clk); #1;
    if (dm_req) dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0; req_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1 || dm_req !== 1'b0) begin
      failures++;
      $display("FAIL wait_entry: stall=%b dm_req=%b, want 1 0", stall, dm_req);
    end
    reset = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    checks++;
    if ({stall, exc, rdata_valid, dm_req, dm_we} !== 5'b0 || dm_be !== 4'h0 ||
        dm_addr !== 32'h0 || dm_wdata !== 32'h0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_in_wait: stall=%b exc=%b rv=%b req=%b be=%h addr=%h rdata=%h, want all zero",
               stall, exc, rdata_valid, dm_req, dm_be, dm_addr, rdata);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    dm_rvalid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (rdata !== 32'h0 || rdata_valid !== 1'b0 || dm_req !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL late_rvalid: rdata=%h rv=%b dm_req=%b stall=%b, want 0 0 0 0",
               rdata, rdata_valid, dm_req, stall);
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = '0;
    req_addr = '0; req_wdata = '0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    test_reset();
    test_reset_in_wait();
    test_store_byte();
    test_load_half();
    test_load_bytes();
    test_back_to_back();
    test_illegal();
    test_gnt_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the MEM stage and the data-memory port: narrows stores (sb/sh/sw) into byte-enables plus lane-replicated write data, and extends loads (lb/lbu/lh/lhu/lw) into 32-bit results. It runs a request/grant/response handshake to a variable-latency data memory and stalls the pipeline until each access completes. Misaligned or illegal accesses raise an exception flag and are never issued.

## Interface
- ADDR_W, 32, byte-address width of req_addr and dm_addr.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM stage holds a memory instruction
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  size/sign: 0 W, 1 H, 2 HU, 3 B, 4 BU; 5-7 illegal
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store source (rt)
- stall  out  1  freeze the pipeline this cycle
- exc  out  1  misaligned/illegal access (AdEL when req_we=0, AdES when req_we=1)
- rdata  out  32  extended load result
- rdata_valid  out  1  one-cycle strobe, rdata valid
- dm_req  out  1  memory request
- dm_we  out  1  write request
- dm_be  out  4  byte enables, bit i = byte lane i
- dm_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- dm_wdata  out  32  lane-replicated store data
- dm_gnt  in  1  memory accepted the request
- dm_rvalid  in  1  load data valid
- dm_rdata  in  32  load word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if req_valid and legal -> latch we/op/addr/wdata, stall=1 (combinational), go REQ. If req_valid and illegal -> exc=1, stall=0, stay IDLE, no dm access.
- Illegal: op 5-7; W with addr[1:0]≠0; H/HU with addr[0]≠0.
- REQ: dm_req=1, stall=1; dm_* driven only from latched fields. On dm_gnt: store -> DONE; load -> WAIT, or -> DONE directly if dm_rvalid is also 1 that cycle (data captured).
- WAIT: stall=1; on dm_rvalid capture extended data into rdata -> DONE.
- DONE: stall=0, rdata_valid=1 for loads only (0 for stores); -> IDLE. The pipeline advances on this cycle, so the req_valid still high in DONE belongs to the finished instruction and is ignored.
- Byte enables: W 1111; H/HU addr[1]?1100:0011; B/BU 0001<<addr[1:0].
- Write data: W pass-through; H {wdata[15:0],wdata[15:0]}; B wdata[7:0] replicated ×4.
- Load extract: byte = dm_rdata[8*addr[1:0]+:8], half = dm_rdata[16*addr[1]+:16]. B/H sign-extend, BU/HU zero-extend, W pass-through. Little-endian.
- dm_gnt outside REQ and dm_rvalid outside REQ/WAIT are ignored.
- rdata holds its last value until the next load capture.

## Timing
- Reset (synchronous): state IDLE; dm_req 0, dm_we 0, dm_be 0, dm_addr 0, dm_wdata 0, rdata 0, rdata_valid 0, exc 0, stall 0 while reset is high.
- Reset mid-access (REQ/WAIT): abort, IDLE next edge, dm_req low from that edge, late dm_rvalid ignored.
- Minimum latency (gnt in first REQ cycle, load rvalid same cycle): 2 stall cycles, DONE on 3rd cycle.
- Load with rvalid one cycle after gnt: 3 stall cycles.
- dm_req stays high and dm_* stay stable from entry to REQ until the dm_gnt cycle inclusive.
- exc is combinational, same cycle as req_valid, and only in IDLE.

## Structure
- Shared package/header lsu_defs: req_op encodings (OP_W, OP_H, OP_HU, OP_B, OP_BU), FSM state encodings.
- Sub-module load_ext: combinational (dm_rdata, addr[1:0], op) -> 32-bit extended data. Store byte-enable/data generation stays inline.

## Test plan
- sb, addr 0x0000_1003, wdata 0x1234_56AB, gnt in first REQ cycle -> dm_be=1000, dm_wdata=0xABAB_ABAB, dm_addr=0x0000_1000, stall 2 cycles, rdata_valid stays 0.
- lh, addr 0x...2, dm_rdata=0x8001_7FFF, rvalid 1 cycle after gnt -> rdata=0xFFFF_8001 in DONE, 3 stall cycles; lhu same data -> 0x0000_8001.
- lb/lbu all four offsets of dm_rdata=0x80FF_7F01 -> lb gives 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80; lbu gives 0x01, 0x7F, 0xFF, 0x80 zero-extended.
- sw to addr 0x...2; lh to 0x...1; op=6 -> exc=1 same cycle, stall=0, dm_req never asserts.
- dm_gnt withheld 5 cycles -> dm_req and dm_* stable, stall high throughout; then gnt -> DONE one cycle later.
- reset asserted in WAIT, dm_rvalid arriving during reset -> all outputs zero, IDLE, rdata unchanged from 0, no rdata_valid.
